// File: rtl/conv1d_mc_engine.sv
// Multi-channel streaming FIR over channel-interleaved samples using one shared MAC; build option CONV1D_MC_SAT_EN saturates the output (default wraps).
// Latency: input handshake in cycle 0, T MAC cycles, out_valid_o from cycle T+1; one sample per T+2 cycles with the output sink always ready.
// Backpressure: result held stable while out_ready_i is low; no new input is accepted until the output handshakes.
module conv1d_mc_engine #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int ACC_W    = 40,
    parameter int OUT_W    = 16,
    parameter int MAX_TAPS = 8,
    parameter int NUM_CH   = 4,
    localparam int TW = $clog2(MAX_TAPS + 1),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IW = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [TW-1:0]            cfg_taps_i,
    input  logic [5:0]               cfg_shift_i,
    input  logic [15:0]              cfg_len_i,
    input  logic                     start_i,
    input  logic                     coef_we_i,
    input  logic [CW-1:0]            coef_ch_i,
    input  logic [IW-1:0]            coef_idx_i,
    input  logic signed [COEF_W-1:0] coef_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [DATA_W-1:0] in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [OUT_W-1:0]  out_data_o,
    output logic [CW-1:0]            out_ch_o,
    output logic                     busy_o,
    output logic                     done_int_o
);

    localparam int PW = DATA_W + COEF_W;

    typedef enum logic [1:0] {IDLE, ACCEPT, MAC, OUT} state_t;

    state_t                   state;
    logic signed [COEF_W-1:0] coef_q [NUM_CH][MAX_TAPS];
    logic signed [DATA_W-1:0] hist_q [NUM_CH][MAX_TAPS];
    logic [TW-1:0]            taps_q;
    logic [TW-1:0]            taps_eff;
    logic [TW-1:0]            tap_k;
    logic [IW-1:0]            k_idx;
    logic [5:0]               shift_q;
    logic [15:0]              len_q;
    logic [15:0]              round_q;
    logic [CW-1:0]            ch_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [PW-1:0]     mul_a;
    logic signed [PW-1:0]     mul_b;
    logic signed [PW-1:0]     mul_p;
    logic signed [ACC_W:0]    rnd_bias;
    logic signed [ACC_W:0]    rnd_sum;
    logic signed [ACC_W:0]    shifted;
    logic signed [OUT_W-1:0]  res;
    logic                     last_tap;
    logic                     last_ch;
    logic                     last_sample;
    logic                     coef_wr_ok;

`ifdef CONV1D_MC_SAT_EN
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    // Clamp the requested kernel length into 1..MAX_TAPS.
    always_comb begin
        taps_eff = cfg_taps_i;
        if (cfg_taps_i == '0) begin
            taps_eff = TW'(1);
        end else if (32'(cfg_taps_i) > MAX_TAPS) begin
            taps_eff = TW'(MAX_TAPS);
        end
    end

    // Shared MAC, round-half-up shift and output width reduction for the current tap.
    always_comb begin
        k_idx    = tap_k[IW-1:0];
        mul_a    = PW'(coef_q[ch_q][k_idx]);
        mul_b    = PW'(hist_q[ch_q][k_idx]);
        mul_p    = mul_a * mul_b;
        acc_next = acc_q + ACC_W'(mul_p);
        rnd_bias = '0;
        if (shift_q != 6'd0) begin
            rnd_bias = (ACC_W+1)'(1) << (shift_q - 6'd1);
        end
        rnd_sum = (ACC_W+1)'(acc_next) + rnd_bias;
        shifted = rnd_sum >>> shift_q;
`ifdef CONV1D_MC_SAT_EN
        if (shifted > SAT_MAX) begin
            res = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            res = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res = OUT_W'(shifted);
        end
`else
        res = OUT_W'(shifted);
`endif
    end

    // Sequencing conditions: last tap of a sample, last channel of a round, last sample of the run.
    always_comb begin
        last_tap    = (tap_k == taps_q - TW'(1));
        last_ch     = (32'(ch_q) == NUM_CH - 1);
        last_sample = last_ch && (round_q == len_q - 16'd1);
        coef_wr_ok  = coef_we_i && (32'(coef_ch_i) < NUM_CH) && (32'(coef_idx_i) < MAX_TAPS);
    end

    // Coefficient bank: writable only while idle so a running kernel never changes underneath.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < MAX_TAPS; i++) begin
                    coef_q[c][i] <= '0;
                end
            end
        end else if (state == IDLE && coef_wr_ok) begin
            coef_q[coef_ch_i][coef_idx_i] <= coef_data_i;
        end
    end

    // Control FSM with history, accumulator and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            taps_q      <= TW'(1);
            shift_q     <= '0;
            len_q       <= '0;
            round_q     <= '0;
            ch_q        <= '0;
            tap_k       <= '0;
            acc_q       <= '0;
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_ch_o    <= '0;
            busy_o      <= 1'b0;
            done_int_o  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < MAX_TAPS; i++) begin
                    hist_q[c][i] <= '0;
                end
            end
        end else begin
            done_int_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        taps_q  <= taps_eff;
                        shift_q <= cfg_shift_i;
                        len_q   <= cfg_len_i;
                        round_q <= '0;
                        ch_q    <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            for (int i = 0; i < MAX_TAPS; i++) begin
                                hist_q[c][i] <= '0;
                            end
                        end
                        if (cfg_len_i == 16'd0) begin
                            done_int_o <= 1'b1;
                        end else begin
                            state      <= ACCEPT;
                            in_ready_o <= 1'b1;
                            busy_o     <= 1'b1;
                        end
                    end
                end
                ACCEPT: begin
                    if (in_valid_i) begin
                        for (int i = MAX_TAPS - 1; i > 0; i--) begin
                            hist_q[ch_q][i] <= hist_q[ch_q][i-1];
                        end
                        hist_q[ch_q][0] <= in_data_i;
                        acc_q      <= '0;
                        tap_k      <= '0;
                        in_ready_o <= 1'b0;
                        state      <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_next;
                    tap_k <= tap_k + TW'(1);
                    if (last_tap) begin
                        out_data_o  <= res;
                        out_ch_o    <= ch_q;
                        out_valid_o <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        ch_q        <= last_ch ? '0 : ch_q + CW'(1);
                        if (last_ch) begin
                            round_q <= round_q + 16'd1;
                        end
                        if (last_sample) begin
                            state      <= IDLE;
                            busy_o     <= 1'b0;
                            done_int_o <= 1'b1;
                        end else begin
                            state      <= ACCEPT;
                            in_ready_o <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1d_mc_engine.sv
// Directed bench for conv1d_mc_engine with two channels and default widths.
// Each scenario task drives a run and compares outputs/timing against hand-computed values.
// Saturation expectations follow CONV1D_MC_SAT_EN when the bench is compiled.
module tb_conv1d_mc_engine;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         cfg_taps;
    logic [5:0]         cfg_shift;
    logic [15:0]        cfg_len;
    logic               start;
    logic               coef_we;
    logic [0:0]         coef_ch;
    logic [2:0]         coef_idx;
    logic signed [15:0] coef_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [0:0]         out_ch;
    logic               busy;
    logic               done_int;

    int errors = 0;
    int checks = 0;

    int in_q[$];
    int out_d[$];
    int out_c[$];
    int acc_cyc[$];
    int ohs_cyc[$];
    int done_cyc;
    logic busy_first;
    logic busy_at_done;
    logic done_after;

    always #5 clk = ~clk;

    conv1d_mc_engine #(.NUM_CH(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_taps_i(cfg_taps), .cfg_shift_i(cfg_shift), .cfg_len_i(cfg_len), .start_i(start),
        .coef_we_i(coef_we), .coef_ch_i(coef_ch), .coef_idx_i(coef_idx), .coef_data_i(coef_data),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_ch_o(out_ch),
        .busy_o(busy), .done_int_o(done_int)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int ch, input int idx, input int val);
        coef_we   = 1'b1;
        coef_ch   = 1'(ch);
        coef_idx  = 3'(idx);
        coef_data = 16'(val);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic clear_coefs();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 8; i++)
                write_coef(c, i, 0);
    endtask

    // Starts a run, streams in_q with out_ready held high, records outputs and handshake cycles.
    task automatic do_run(input int taps, input int shift, input int len);
        int idx;
        out_d.delete(); out_c.delete(); acc_cyc.delete(); ohs_cyc.delete();
        done_cyc  = -1;
        idx       = 0;
        cfg_taps  = 4'(taps);
        cfg_shift = 6'(shift);
        cfg_len   = 16'(len);
        start     = 1'b1;
        tick();
        start      = 1'b0;
        busy_first = busy;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done_int) begin
                done_cyc     = cyc;
                busy_at_done = busy;
                break;
            end
            in_valid  = (idx < in_q.size());
            in_data   = 16'(0);
            if (in_valid) in_data = 16'(in_q[idx]);
            out_ready = 1'b1;
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            if (out_valid) begin
                out_d.push_back(int'(out_data));
                out_c.push_back(int'(out_ch));
                ohs_cyc.push_back(cyc);
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        done_after = done_int;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, busy, done_int} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000", {in_ready, out_valid, busy, done_int});
        end
        checks++;
        if (out_data !== 16'sd0 || out_ch !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got=%0d/ch%0d exp=0/ch0", out_data, out_ch);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_impulse();
        int exp_d[$];
        int exp_c[$];
        int last_ohs;
        clear_coefs();
        write_coef(0, 0, 1); write_coef(0, 1, 2); write_coef(0, 2, 3);
        write_coef(1, 0, 1); write_coef(1, 1, 2); write_coef(1, 2, 3);
        in_q  = '{1, 0, 0, 1, 0, 0, 0, 0};
        exp_d = '{1, 0, 2, 1, 3, 2, 0, 3};
        exp_c = '{0, 1, 0, 1, 0, 1, 0, 1};
        do_run(3, 0, 4);
        checks++;
        if (out_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL impulse_count got=%0d exp=%0d", out_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== exp_d[i] || out_c[i] !== exp_c[i]) begin
                errors++;
                $display("FAIL impulse_out[%0d] got=%0d/ch%0d exp=%0d/ch%0d", i, out_d[i], out_c[i], exp_d[i], exp_c[i]);
            end
        end
        for (int i = 0; i < acc_cyc.size() && i < ohs_cyc.size(); i++) begin
            checks++;
            if (ohs_cyc[i] - acc_cyc[i] !== 4) begin
                errors++;
                $display("FAIL impulse_latency[%0d] got=%0d exp=4", i, ohs_cyc[i] - acc_cyc[i]);
            end
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 5) begin
                errors++;
                $display("FAIL impulse_period[%0d] got=%0d exp=5", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        last_ohs = (ohs_cyc.size() > 0) ? ohs_cyc[ohs_cyc.size()-1] : -10;
        checks++;
        if (done_cyc !== last_ohs + 1) begin
            errors++;
            $display("FAIL impulse_done_cycle got=%0d exp=%0d", done_cyc, last_ohs + 1);
        end
        checks++;
        if (busy_first !== 1'b1 || busy_at_done !== 1'b0 || done_after !== 1'b0) begin
            errors++;
            $display("FAIL impulse_busy_done got=%b%b%b exp=100", busy_first, busy_at_done, done_after);
        end
    endtask

    task automatic test_rounding();
        int exp_d[$];
        write_coef(0, 0, 3);
        write_coef(1, 0, -3);
        in_q  = '{1, 1, -1, 5};
        exp_d = '{2, -1, -1, -7};
        do_run(1, 1, 2);
        checks++;
        if (out_d.size() != exp_d.size() || done_cyc < 0) begin
            errors++;
            $display("FAIL round_count got=%0d done=%0d exp=%0d", out_d.size(), done_cyc, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL round_out[%0d] got=%0d exp=%0d", i, out_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_d[$];
        write_coef(0, 0, 32767);
        write_coef(1, 0, -32767);
        in_q = '{32767, 32767};
`ifdef CONV1D_MC_SAT_EN
        exp_d = '{32767, -32768};
`else
        exp_d = '{1, -1};
`endif
        do_run(1, 0, 1);
        checks++;
        if (out_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL sat_count got=%0d exp=%0d", out_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL sat_out[%0d] got=%0d exp=%0d", i, out_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_multichannel();
        int exp_d[$];
        int exp_c[$];
        clear_coefs();
        write_coef(0, 0, 1); write_coef(0, 1, 1);
        write_coef(1, 0, 2); write_coef(1, 1, 0);
        in_q  = '{5, 7, 1, 3};
        exp_d = '{5, 14, 6, 6};
        exp_c = '{0, 1, 0, 1};
        do_run(2, 0, 2);
        checks++;
        if (out_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL mc_count got=%0d exp=%0d", out_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== exp_d[i] || out_c[i] !== exp_c[i]) begin
                errors++;
                $display("FAIL mc_out[%0d] got=%0d/ch%0d exp=%0d/ch%0d", i, out_d[i], out_c[i], exp_d[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_taps_zero();
        int exp_d[$];
        clear_coefs();
        write_coef(0, 0, 2); write_coef(0, 1, 5);
        write_coef(1, 0, 3); write_coef(1, 1, 7);
        in_q  = '{4, 1, 10, 1};
        exp_d = '{8, 3, 20, 3};
        do_run(0, 0, 2);
        checks++;
        if (out_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL taps0_count got=%0d exp=%0d", out_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL taps0_out[%0d] got=%0d exp=%0d", i, out_d[i], exp_d[i]);
            end
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 3) begin
                errors++;
                $display("FAIL taps0_period[%0d] got=%0d exp=3", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    task automatic test_len_zero();
        in_q = '{5, 5};
        do_run(2, 0, 0);
        checks++;
        if (done_cyc !== 0) begin
            errors++;
            $display("FAIL len0_done_cycle got=%0d exp=0", done_cyc);
        end
        checks++;
        if (acc_cyc.size() !== 0 || busy_at_done !== 1'b0 || done_after !== 1'b0) begin
            errors++;
            $display("FAIL len0_state got=acc%0d busy%b done_after%b exp=acc0 busy0 done_after0", acc_cyc.size(), busy_at_done, done_after);
        end
    endtask

    task automatic test_backpressure();
        int  got_d[$];
        int  got_c[$];
        logic seen_done;
        clear_coefs();
        write_coef(0, 0, 1);
        write_coef(1, 0, 1);
        cfg_taps  = 4'd1;
        cfg_shift = 6'd0;
        cfg_len   = 16'd1;
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'sd1234;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 20 && !out_valid; n++) tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_out_valid got=%b exp=1", out_valid);
        end
        coef_we   = 1'b1;
        coef_ch   = 1'b0;
        coef_idx  = 3'd0;
        coef_data = 16'sd99;
        start     = 1'b1;
        cfg_len   = 16'd5;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'sd1234 || out_ch !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got=v%b d%0d ch%0d rdy%b busy%b exp=v1 d1234 ch0 rdy0 busy1", n, out_valid, out_data, out_ch, in_ready, busy);
            end
        end
        coef_we   = 1'b0;
        start     = 1'b0;
        cfg_len   = 16'd1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'sd77;
        seen_done = 1'b0;
        for (int n = 0; n < 30 && !seen_done; n++) begin
            if (done_int) seen_done = 1'b1;
            else begin
                if (out_valid) begin
                    got_d.push_back(int'(out_data));
                    got_c.push_back(int'(out_ch));
                end
                tick();
            end
        end
        in_valid = 1'b0;
        checks++;
        if (seen_done !== 1'b1 || got_d.size() != 2) begin
            errors++;
            $display("FAIL bp_finish got=done%b outs%0d exp=done1 outs2", seen_done, got_d.size());
        end
        checks++;
        if (got_d.size() < 2 || got_d[0] !== 1234 || got_d[1] !== 77 || got_c[1] !== 1) begin
            errors++;
            $display("FAIL bp_outs got=%0d outputs exp=1234/ch0,77/ch1", got_d.size());
        end
        tick();
        in_q = '{3, 5};
        do_run(1, 0, 1);
        checks++;
        if (out_d.size() != 2 || out_d[0] !== 3 || out_d[1] !== 5) begin
            errors++;
            $display("FAIL bp_coef_guard got=%0d outputs first=%0d exp=3,5", out_d.size(), (out_d.size() > 0) ? out_d[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        clear_coefs();
        write_coef(0, 0, 1); write_coef(0, 1, 1); write_coef(0, 2, 1);
        cfg_taps  = 4'd3;
        cfg_shift = 6'd0;
        cfg_len   = 16'd2;
        start     = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'sd100;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before got=%b exp=1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, done_int, out_data, out_ch} !== 21'd0) begin
            errors++;
            $display("FAIL midrst_outputs got=%b exp=0", {in_ready, out_valid, busy, done_int, out_data, out_ch});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        in_q = '{9, 4};
        do_run(3, 0, 1);
        checks++;
        if (out_d.size() != 2 || out_d[0] !== 0 || out_d[1] !== 0) begin
            errors++;
            $display("FAIL midrst_coef_cleared got=%0d outputs first=%0d exp=0,0", out_d.size(), (out_d.size() > 0) ? out_d[0] : -1);
        end
        write_coef(0, 0, 1); write_coef(0, 1, 1); write_coef(0, 2, 1);
        write_coef(1, 0, 2);
        do_run(3, 0, 1);
        checks++;
        if (out_d.size() != 2 || out_d[0] !== 9 || out_d[1] !== 8) begin
            errors++;
            $display("FAIL midrst_hist_cleared got=%0d outputs first=%0d exp=9,8", out_d.size(), (out_d.size() > 0) ? out_d[0] : -1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_taps  = '0;
        cfg_shift = '0;
        cfg_len   = '0;
        start     = 1'b0;
        coef_we   = 1'b0;
        coef_ch   = '0;
        coef_idx  = '0;
        coef_data = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_impulse();
        test_rounding();
        test_saturation();
        test_multichannel();
        test_taps_zero();
        test_len_zero();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout exp=completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv1d_mc_engine.md
# conv1d_mc_engine

Parametrised multi-channel streaming 1D convolution engine; successor to the single-channel conv1d accelerator. It computes a per-channel FIR convolution over channel-interleaved input samples, using one time-multiplexed MAC. Output is rounded, shifted and saturated, and the engine raises a done interrupt after a programmed number of samples per channel. It sits behind the conv1d register-file/OBI glue, which drives the config, coefficient and stream ports.

## Interface
- `DATA_W`, 16: signed input sample width.
- `COEF_W`, 16: signed coefficient width.
- `ACC_W`, 40: signed accumulator width; must satisfy ≥ `DATA_W`+`COEF_W`+$clog2(`MAX_TAPS`).
- `OUT_W`, 16: signed output width.
- `MAX_TAPS`, 8: maximum kernel length.
- `NUM_CH`, 4: number of independent channels.
- Derived widths: `TW` = $clog2(`MAX_TAPS`+1); `CW` = max(1, $clog2(`NUM_CH`)); `IW` = max(1, $clog2(`MAX_TAPS`)).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; one clock, asynchronous active-low reset.
- `cfg_taps_i` in `TW`: kernel length, latched at start.
- `cfg_shift_i` in 6: right shift applied to the accumulator, latched at start.
- `cfg_len_i` in 16: samples per channel, latched at start.
- `start_i` in 1: start pulse.
- `coef_we_i`, `coef_ch_i`[`CW`], `coef_idx_i`[`IW`], `coef_data_i`[`COEF_W`] in: coefficient write port.
- `in_valid_i` in 1 / `in_ready_o` out 1 / `in_data_i` in `DATA_W`: input stream.
- `out_valid_o` out 1 / `out_ready_i` in 1 / `out_data_o` out `OUT_W` / `out_ch_o` out `CW`: output stream.
- `busy_o` out 1: high in every state except IDLE.
- `done_int_o` out 1: one-cycle completion pulse.

## Operation
- Output per sample: y_c[n] = Σ_{k=0}^{T-1} w_c[k]·x_c[n−k].
  - x_c with a negative index is 0; history is cleared at start.
- Effective tap count T is `cfg_taps_i` clamped into 1..`MAX_TAPS`: 0 becomes 1, and values above `MAX_TAPS` become `MAX_TAPS`.
- Coefficient storage:
  - `NUM_CH`×`MAX_TAPS` registers, reset to 0.
  - A write takes effect when `coef_we_i` is high in IDLE.
  - Writes outside IDLE are ignored.
  - Out-of-range `coef_ch_i` or `coef_idx_i` values are ignored.
- Input order is strictly round-robin, ch0, ch1, …, ch`NUM_CH`−1, then repeating. The channel counter restarts at 0 on each start.
- FSM states: IDLE, ACCEPT, MAC, OUT.
  - IDLE → ACCEPT on `start_i`. If latched len = 0, IDLE stays IDLE and `done_int_o` pulses the next cycle.
  - ACCEPT: `in_ready_o`=1. On handshake, the sample is shifted into the channel's history, the accumulator is cleared, and the FSM goes to MAC.
  - MAC: one tap per cycle, k = 0..T−1, for T cycles. Then the rounded result is registered into `out_data_o` and the FSM goes to OUT.
  - OUT: `out_valid_o`=1. On handshake, the FSM goes to ACCEPT. After the last sample (len·`NUM_CH` total), it goes to IDLE and pulses `done_int_o`.
- `start_i` outside IDLE is ignored.
- Arithmetic:
  - Full-precision signed MAC in `ACC_W`.
  - If s > 0: r = (acc + 2^(s−1)) >>> s (arithmetic shift). If s = 0: r = acc.
  - r is then reduced to `OUT_W` as described under Configuration.
- `out_data_o` and `out_ch_o` are stable while `out_valid_o` is high and `out_ready_i` is low.
- Reset, including mid-operation: FSM to IDLE; history, counters, accumulator and coefficients cleared.
- Reset values of all outputs: `in_ready_o`, `out_valid_o`, `busy_o` and `done_int_o` are 0; `out_data_o` and `out_ch_o` are 0.

## Timing
- Input handshake in cycle 0.
- MAC runs in cycles 1..T.
- `out_valid_o` is high from cycle T+1.
- If the output handshakes in cycle c, `in_ready_o` is high again in cycle c+1.
- With `out_ready_i` held high, throughput is one sample per T+2 cycles.
- `done_int_o` is high exactly in cycle c+1 after the final output handshake, the same cycle `busy_o` falls.
- All outputs are registered; there is no combinational path from `in_valid_i` or `out_ready_i` to any output.

## Configuration
- Macro: `CONV1D_MC_SAT_EN`.
- Defined: r is saturated to [−2^(`OUT_W`−1), 2^(`OUT_W`−1)−1].
- Undefined: r is truncated to its low `OUT_W` bits (two's-complement wrap) and the saturation logic is not built.

## Test plan
- Impulse: `NUM_CH`=1, T=3, w=[1,2,3], s=0, len=4, inputs 1,0,0,0 → outputs 1,2,3,0; done pulse one cycle after the 4th output handshake.
- Rounding and sign: T=1, w=[3], s=1.
  - Input 1 → output 2.
  - With w=[−3], input 1 → output −1.
- Saturation: T=1, w=[32767], input 32767, s=0.
  - With `CONV1D_MC_SAT_EN`: output 32767.
  - Without it: output 1.
- Multi-channel: `NUM_CH`=2, len=2, T=2.
  - Coefficients: ch0 w=[1,1]; ch1 w=[2,0].
  - Inputs 5,7,1,3 → outputs (5,ch0), (14,ch1), (6,ch0), (6,ch1).
- Backpressure and guards:
  - Hold `out_ready_i` low for 10 cycles: `out_valid_o` stays high with data stable, `in_ready_o` stays 0.
  - A coefficient write while busy is ignored.
  - `start_i` while busy is ignored.
- Boundary and reset:
  - len=0: `done_int_o` pulses the cycle after `start_i` and no input is accepted.
  - `cfg_taps_i`=0: behaves as T=1.
  - `rst_ni` asserted mid-MAC: all outputs 0 at once; a following run's results show cleared history and coefficients.
